// File: rtl/apu_mixer.sv
// APU channel mixer: weighted sum of five channels, one channel per cycle, scaled to N bits.
// Optional DC-blocking filter stage enabled by defining APU_MIXER_DC_FILTER_EN.
module apu_mixer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         start,
    input  logic [3:0]   pulse1,
    input  logic [3:0]   pulse2,
    input  logic [3:0]   triangle,
    input  logic [3:0]   noise,
    input  logic [6:0]   dmc,
    input  logic [4:0]   mask,
    output logic [N-1:0] audio,
    output logic         valid,
    output logic         busy
);

`ifdef APU_MIXER_DC_FILTER_EN
    typedef enum logic [1:0] {StIdle, StAcc, StFilt, StOut} state_e;
    localparam logic [N-1:0] AudioRst = N'(128);
`else
    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;
    localparam logic [N-1:0] AudioRst = '0;
`endif

    state_e       state_q;
    logic [9:0]   acc_q;
    logic [2:0]   idx_q;
    logic [3:0]   p1_q, p2_q, tri_q, noi_q;
    logic [6:0]   dmc_q;
    logic [4:0]   mask_q;
    logic [N-1:0] audio_q;
    logic         valid_q;
    logic         busy_q;

    logic [9:0]   term;
    logic [9:0]   acc_sum;
    logic [9:0]   mix_sat;

    // Weighted contribution of the channel selected by idx_q.
    always_comb begin
        term = '0;
        case (idx_q)
            3'd0: term = mask_q[0] ? 10'd0 : 10'(p1_q) * 10'd8;
            3'd1: term = mask_q[1] ? 10'd0 : 10'(p2_q) * 10'd8;
            3'd2: term = mask_q[2] ? 10'd0 : 10'(tri_q) * 10'd9;
            3'd3: term = mask_q[3] ? 10'd0 : 10'(noi_q) * 10'd5;
            3'd4: term = mask_q[4] ? 10'd0 : 10'(dmc_q) * 10'd3;
            default: term = '0;
        endcase
    end

    always_comb begin
        acc_sum = acc_q + term;
        mix_sat = ((acc_sum >> 2) > 10'd255) ? 10'd255 : (acc_sum >> 2);
    end

`ifdef APU_MIXER_DC_FILTER_EN
    logic [9:0]         x_prev_q;
    logic signed [17:0] y_prev_q;
    logic signed [17:0] y;
    logic signed [17:0] y_biased;
    logic [7:0]         filt_sat;

    // First-order high-pass; 18 bits covers the worst-case recursive gain of ~32x.
    always_comb begin
        y = $signed({8'b0, acc_q}) - $signed({8'b0, x_prev_q}) + y_prev_q - (y_prev_q >>> 5);
        y_biased = 18'sd128 + (y >>> 2);
        if (y_biased < 18'sd0) begin
            filt_sat = 8'd0;
        end else if (y_biased > 18'sd255) begin
            filt_sat = 8'd255;
        end else begin
            filt_sat = y_biased[7:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            idx_q    <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            tri_q    <= '0;
            noi_q    <= '0;
            dmc_q    <= '0;
            mask_q   <= '0;
            audio_q  <= AudioRst;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef APU_MIXER_DC_FILTER_EN
            x_prev_q <= '0;
            y_prev_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        p1_q    <= pulse1;
                        p2_q    <= pulse2;
                        tri_q   <= triangle;
                        noi_q   <= noise;
                        dmc_q   <= dmc;
                        mask_q  <= mask;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    acc_q <= acc_sum;
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd4) begin
`ifdef APU_MIXER_DC_FILTER_EN
                        state_q <= StFilt;
`else
                        // Audio lands on the final accumulate edge; OUT is the valid cycle.
                        audio_q <= N'(mix_sat);
                        valid_q <= 1'b1;
                        state_q <= StOut;
`endif
                    end
                end
`ifdef APU_MIXER_DC_FILTER_EN
                StFilt: begin
                    x_prev_q <= acc_q;
                    y_prev_q <= y;
                    audio_q  <= N'(filt_sat);
                    valid_q  <= 1'b1;
                    state_q  <= StOut;
                end
`endif
                StOut: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign audio = audio_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_apu_mixer.sv
// Randomized and directed bench for apu_mixer with a cycle-count behavioural model.
module tb_apu_mixer;

`ifdef APU_MIXER_DC_FILTER_EN
    localparam int Lat = 7;
    localparam logic [7:0] AudioRst = 8'h80;
`else
    localparam int Lat = 6;
    localparam logic [7:0] AudioRst = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pulse1 = '0, pulse2 = '0, triangle = '0, noise = '0;
    logic [6:0] dmc = '0;
    logic [4:0] mask = '0;
    logic [7:0] audio;
    logic       valid;
    logic       busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    apu_mixer #(.N(8)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .start    (start),
        .pulse1   (pulse1),
        .pulse2   (pulse2),
        .triangle (triangle),
        .noise    (noise),
        .dmc      (dmc),
        .mask     (mask),
        .audio    (audio),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a mix accepted in idle completes Lat edges later.
    int         m_cnt;
    int         m_sum;
    int         m_fx, m_fy;
    logic [7:0] m_audio;

    function automatic int weighted_sum(input int p1, p2, tr, no, dm, input logic [4:0] mk);
        int s;
        s = 0;
        if (!mk[0]) s += 8 * p1;
        if (!mk[1]) s += 8 * p2;
        if (!mk[2]) s += 9 * tr;
        if (!mk[3]) s += 5 * no;
        if (!mk[4]) s += 3 * dm;
        return s;
    endfunction

    always @(posedge clk or negedge n_reset) begin
        int y, a;
        if (!n_reset) begin
            m_cnt   <= 0;
            m_sum   <= 0;
            m_fx    <= 0;
            m_fy    <= 0;
            m_audio <= AudioRst;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_sum <= weighted_sum(int'(pulse1), int'(pulse2), int'(triangle), int'(noise),
                                      int'(dmc), mask);
                m_cnt <= 1;
            end
        end else if (m_cnt < Lat) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == Lat) begin
`ifdef APU_MIXER_DC_FILTER_EN
                y = m_sum - m_fx + m_fy - (m_fy >>> 5);
                a = 128 + (y >>> 2);
                m_fx <= m_sum;
                m_fy <= y;
`else
                a = m_sum / 4;
`endif
                m_audio <= (a < 0) ? 8'd0 : (a > 255) ? 8'd255 : 8'(a);
            end
        end else begin
            m_cnt <= 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", int'(valid), int'(m_cnt == Lat));
            check("busy", int'(busy), int'(m_cnt != 0));
            check("audio", int'(audio), int'(m_audio));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        pulse1   = 4'($urandom);
        pulse2   = 4'($urandom);
        triangle = 4'($urandom);
        noise    = 4'($urandom);
        dmc      = 7'($urandom);
        mask     = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
    endtask

    // One mix with inputs scrambled after the strobe; returns edges to valid.
    task automatic do_mix(input logic [3:0] p1, p2, tr, no, input logic [6:0] dm,
                          input logic [4:0] mk, output int lat);
        pulse1 = p1; pulse2 = p2; triangle = tr; noise = no; dmc = dm; mask = mk;
        start = 1'b1;
        step();
        start = 1'b0;
        scramble();
        check("busy_after_start", int'(busy), 1);
        lat = 1;
        while (!valid && lat < 30) begin
            step();
            lat++;
        end
        check("latency", lat, Lat);
    endtask

    initial begin
        int lat, nvalid;
        #1 n_reset = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_audio", int'(audio), int'(AudioRst));
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        repeat (3) step();
        n_reset = 1'b1;
        repeat (20) step();
        check("idle_audio", int'(audio), int'(AudioRst));
        check("idle_busy", int'(busy), 0);

        do_mix(4'd15, 4'd15, 4'd0, 4'd0, 7'd0, 5'd0, lat);
`ifndef APU_MIXER_DC_FILTER_EN
        check("pulses_60", int'(audio), 60);
`endif
        step();
        check("valid_one_cycle", int'(valid), 0);
        check("busy_done", int'(busy), 0);

        do_mix(4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 5'd0, lat);
`ifndef APU_MIXER_DC_FILTER_EN
        check("all_max_207", int'(audio), 207);
`endif
        // Start during the valid cycle is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_on_valid_ignored", int'(busy), 0);
        repeat (3) step();

        do_mix(4'd15, 4'd0, 4'd10, 4'd0, 7'd0, 5'b00001, lat);
`ifndef APU_MIXER_DC_FILTER_EN
        check("mask_22", int'(audio), 22);
`endif
        // Start one cycle after valid is accepted.
        step();
        do_mix(4'd3, 4'd7, 4'd1, 4'd9, 7'd50, 5'd0, lat);
`ifndef APU_MIXER_DC_FILTER_EN
        check("mix_after_valid", int'(audio), (24 + 56 + 9 + 45 + 150) / 4);
`endif
        step();

        // Second start while busy is dropped.
        pulse1 = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        nvalid = 0;
        repeat (15) begin
            step();
            if (valid) nvalid++;
        end
        check("one_valid_only", nvalid, 1);

        // Reset mid-mix aborts.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        n_reset = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_audio", int'(audio), int'(AudioRst));
        step();
        n_reset = 1'b1;
        nvalid = 0;
        repeat (10) begin
            step();
            if (valid) nvalid++;
        end
        check("abort_no_valid", nvalid, 0);

        for (int i = 0; i < 600; i++) begin
            scramble();
            start = ($urandom_range(0, 3) == 0);
            step();
        end
        start = 1'b0;
        repeat (10) step();

`ifdef APU_MIXER_DC_FILTER_EN
        for (int i = 0; i < 200; i++) begin
            do_mix(4'd8, 4'd8, 4'd8, 4'd8, 7'd64, 5'd0, lat);
            step();
        end
        check("dc_settle", int'(audio >= 8'd128 && audio <= 8'd136), 1);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
